// File: rtl/load_store_queue_if.sv
// Dispatch, CDB-snoop and head-issue signal bundle for the load/store queue.
// The slave side is the queue; the master side is dispatch plus the memory unit.
interface load_store_queue_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic              disp_valid_i;
  logic              disp_ready_o;
  logic              disp_load_i;
  logic [TAG_W-1:0]  disp_ld_tag_i;
  logic [TAG_W-1:0]  disp_base_tag_i;
  logic [DATA_W-1:0] disp_base_val_i;
  logic [DATA_W-1:0] disp_offset_i;
  logic [TAG_W-1:0]  disp_st_tag_i;
  logic [DATA_W-1:0] disp_st_val_i;
  logic [TAG_W-1:0]  cdb_tag_i;
  logic [DATA_W-1:0] cdb_data_i;
  logic              lsu_empty_o;
  logic              lsu_instr_ready_o;
  logic              lsu_load_o;
  logic [DATA_W-1:0] lsu_eff_addr_o;
  logic [DATA_W-1:0] lsu_st_data_o;
  logic [TAG_W-1:0]  lsu_ld_tag_o;
  logic              lsu_read_i;

  modport master (
    output disp_valid_i, disp_load_i, disp_ld_tag_i, disp_base_tag_i, disp_base_val_i,
           disp_offset_i, disp_st_tag_i, disp_st_val_i, cdb_tag_i, cdb_data_i, lsu_read_i,
    input  disp_ready_o, lsu_empty_o, lsu_instr_ready_o, lsu_load_o, lsu_eff_addr_o,
           lsu_st_data_o, lsu_ld_tag_o
  );

  modport slave (
    input  disp_valid_i, disp_load_i, disp_ld_tag_i, disp_base_tag_i, disp_base_val_i,
           disp_offset_i, disp_st_tag_i, disp_st_val_i, cdb_tag_i, cdb_data_i, lsu_read_i,
    output disp_ready_o, lsu_empty_o, lsu_instr_ready_o, lsu_load_o, lsu_eff_addr_o,
           lsu_st_data_o, lsu_ld_tag_o
  );
endinterface

// File: rtl/load_store_queue.sv
// In-order load/store queue: holds memory ops until operands arrive via the CDB,
// then presents the head with its effective address to dmem_read_write_unit.
module load_store_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  load_store_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] NO_VAL = '0;
  localparam logic [PTR_W:0]   FULL   = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic              r_load     [DEPTH];
  logic [TAG_W-1:0]  r_ld_tag   [DEPTH];
  logic [TAG_W-1:0]  r_base_tag [DEPTH];
  logic [DATA_W-1:0] r_base_val [DEPTH];
  logic [DATA_W-1:0] r_offset   [DEPTH];
  logic [TAG_W-1:0]  r_st_tag   [DEPTH];
  logic [DATA_W-1:0] r_st_val   [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic w_empty;
  logic w_disp_ready;
  logic w_head_ready;
  logic w_push;
  logic w_pop;
  logic w_cdb_live;

  // A tag that matches the live broadcast resolves to the broadcast value.
  function automatic logic [TAG_W-1:0] fwd_tag(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] cdb);
    return (tag != NO_VAL && tag == cdb) ? NO_VAL : tag;
  endfunction

  function automatic logic [DATA_W-1:0] fwd_val(input logic [TAG_W-1:0]  tag,
                                                input logic [DATA_W-1:0] val,
                                                input logic [TAG_W-1:0]  cdb,
                                                input logic [DATA_W-1:0] data);
    return (tag != NO_VAL && tag == cdb) ? data : val;
  endfunction

  assign w_empty      = (r_count == '0);
  assign w_disp_ready = (r_count != FULL);
  assign w_head_ready = r_valid[r_head] && (r_base_tag[r_head] == NO_VAL) &&
                        (r_load[r_head] || (r_st_tag[r_head] == NO_VAL));
  assign w_push       = bus.disp_valid_i && w_disp_ready;
  assign w_pop        = bus.lsu_read_i && w_head_ready;
  assign w_cdb_live   = (bus.cdb_tag_i != NO_VAL);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Head and tail never coincide when both fire: a pop needs an entry, a push needs room.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && r_tail == PTR_W'(i)) begin
        r_load[i]     <= bus.disp_load_i;
        r_ld_tag[i]   <= bus.disp_ld_tag_i;
        r_offset[i]   <= bus.disp_offset_i;
        r_base_tag[i] <= fwd_tag(bus.disp_base_tag_i, bus.cdb_tag_i);
        r_base_val[i] <= fwd_val(bus.disp_base_tag_i, bus.disp_base_val_i,
                                 bus.cdb_tag_i, bus.cdb_data_i);
        r_st_tag[i]   <= fwd_tag(bus.disp_st_tag_i, bus.cdb_tag_i);
        r_st_val[i]   <= fwd_val(bus.disp_st_tag_i, bus.disp_st_val_i,
                                 bus.cdb_tag_i, bus.cdb_data_i);
      end else if (r_valid[i] && w_cdb_live) begin
        if (r_base_tag[i] == bus.cdb_tag_i) begin
          r_base_tag[i] <= NO_VAL;
          r_base_val[i] <= bus.cdb_data_i;
        end
        if (r_st_tag[i] == bus.cdb_tag_i) begin
          r_st_tag[i] <= NO_VAL;
          r_st_val[i] <= bus.cdb_data_i;
        end
      end
    end
  end

  // Head fields are forced to neutral values whenever the queue is empty.
  assign bus.disp_ready_o      = w_disp_ready;
  assign bus.lsu_empty_o       = w_empty;
  assign bus.lsu_instr_ready_o = w_head_ready;
  assign bus.lsu_load_o        = w_empty ? 1'b0 : r_load[r_head];
  assign bus.lsu_eff_addr_o    = w_empty ? '0 : r_base_val[r_head] + r_offset[r_head];
  assign bus.lsu_st_data_o     = w_empty ? '0 : r_st_val[r_head];
  assign bus.lsu_ld_tag_o      = w_empty ? NO_VAL : r_ld_tag[r_head];
  assign count_o               = r_count;

endmodule

// File: tb/tb_load_store_queue.sv
// Randomized bench for load_store_queue with a queue-based reference model.
module tb_load_store_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    bit        load;
    bit [3:0]  ld_tag;
    bit [3:0]  bt;
    bit [31:0] bv;
    bit [31:0] off;
    bit [3:0]  stt;
    bit [31:0] stv;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] count;
  ent_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;

  load_store_queue_if #(.DATA_W(32), .TAG_W(TAG_W)) bus();

  load_store_queue #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(TAG_W)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus),
    .count_o   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    if (q.size() == 0) return 1'b0;
    return (q[0].bt == 0) && (q[0].load || q[0].stt == 0);
  endfunction

  task automatic check_outputs();
    chk("empty",      32'(bus.lsu_empty_o),       32'(q.size() == 0));
    chk("instr_rdy",  32'(bus.lsu_instr_ready_o), 32'(m_ready()));
    chk("disp_rdy",   32'(bus.disp_ready_o),      32'(q.size() < DEPTH));
    chk("count",      32'(count),                 32'(q.size()));
    if (q.size() == 0) begin
      chk("load",    32'(bus.lsu_load_o),   32'd0);
      chk("eff",     bus.lsu_eff_addr_o,    32'd0);
      chk("st_data", bus.lsu_st_data_o,     32'd0);
      chk("ld_tag",  32'(bus.lsu_ld_tag_o), 32'd0);
    end else begin
      chk("load",    32'(bus.lsu_load_o),   32'(q[0].load));
      chk("eff",     bus.lsu_eff_addr_o,    q[0].bv + q[0].off);
      chk("st_data", bus.lsu_st_data_o,     q[0].stv);
      chk("ld_tag",  32'(bus.lsu_ld_tag_o), 32'(q[0].ld_tag));
    end
  endtask

  task automatic model_step();
    bit   push, pop;
    bit [3:0] c;
    ent_t e;
    push = bus.disp_valid_i && (q.size() < DEPTH);
    pop  = bus.lsu_read_i && m_ready();
    c    = bus.cdb_tag_i;
    if (c != 0) begin
      foreach (q[i]) begin
        if (q[i].bt == c)  begin q[i].bt  = 0; q[i].bv  = bus.cdb_data_i; end
        if (q[i].stt == c) begin q[i].stt = 0; q[i].stv = bus.cdb_data_i; end
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      e.load   = bus.disp_load_i;
      e.ld_tag = bus.disp_ld_tag_i;
      e.off    = bus.disp_offset_i;
      e.bt     = bus.disp_base_tag_i;
      e.bv     = bus.disp_base_val_i;
      e.stt    = bus.disp_st_tag_i;
      e.stv    = bus.disp_st_val_i;
      if (c != 0 && e.bt == c)  begin e.bt  = 0; e.bv  = bus.cdb_data_i; end
      if (c != 0 && e.stt == c) begin e.stt = 0; e.stv = bus.cdb_data_i; end
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid_i    = 1'b0;
    bus.disp_load_i     = 1'b0;
    bus.disp_ld_tag_i   = '0;
    bus.disp_base_tag_i = '0;
    bus.disp_base_val_i = '0;
    bus.disp_offset_i   = '0;
    bus.disp_st_tag_i   = '0;
    bus.disp_st_val_i   = '0;
    bus.cdb_tag_i       = '0;
    bus.cdb_data_i      = '0;
    bus.lsu_read_i      = 1'b0;
  endtask

  task automatic disp(input bit ld, input bit [3:0] ldt, input bit [3:0] bt, input bit [31:0] bv,
                      input bit [31:0] off, input bit [3:0] stt, input bit [31:0] stv);
    bus.disp_valid_i    = 1'b1;
    bus.disp_load_i     = ld;
    bus.disp_ld_tag_i   = ldt;
    bus.disp_base_tag_i = bt;
    bus.disp_base_val_i = bv;
    bus.disp_offset_i   = off;
    bus.disp_st_tag_i   = stt;
    bus.disp_st_val_i   = stv;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle();
      bus.lsu_read_i = 1'b1;
      cycle();
    end
    idle();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    q.delete();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Ready store, offset wraps the address to zero
    disp(0, 0, 0, 32'h10, 32'hFFFF_FFF0, 0, 32'hAB);
    cycle(); idle();
    chk("tp1_empty", 32'(bus.lsu_empty_o), 32'd0);
    chk("tp1_rdy",   32'(bus.lsu_instr_ready_o), 32'd1);
    chk("tp1_eff",   bus.lsu_eff_addr_o, 32'h0);
    chk("tp1_st",    bus.lsu_st_data_o, 32'hAB);
    bus.lsu_read_i = 1'b1;
    cycle(); idle();
    chk("tp1_pop", 32'(bus.lsu_empty_o), 32'd1);

    // Load waiting on base tag 1, woken by the CDB
    disp(1, 2, 1, 0, 32'd4, 0, 0);
    cycle(); idle();
    chk("tp2_wait", 32'(bus.lsu_instr_ready_o), 32'd0);
    bus.lsu_read_i = 1'b1;
    cycle();
    chk("tp2_cnt", 32'(count), 32'd1);
    bus.cdb_tag_i = 4'd1; bus.cdb_data_i = 32'h100;
    cycle(); idle();
    chk("tp2_rdy", 32'(bus.lsu_instr_ready_o), 32'd1);
    chk("tp2_eff", bus.lsu_eff_addr_o, 32'h104);
    chk("tp2_tag", 32'(bus.lsu_ld_tag_o), 32'd2);
    bus.lsu_read_i = 1'b1;
    cycle(); idle();

    // Fill, overflow attempt, then wrap with concurrent push/pop
    for (int i = 0; i < DEPTH; i++) begin
      disp(1, 4'(i + 3), 0, 32'(i * 16), 32'(i), 0, 0);
      cycle();
    end
    idle();
    chk("tp3_full", 32'(bus.disp_ready_o), 32'd0);
    chk("tp3_cnt",  32'(count), 32'd4);
    disp(1, 4'd9, 0, 32'hDEAD, 0, 0, 0);
    cycle(); idle();
    bus.lsu_read_i = 1'b1;
    cycle(); idle();
    chk("tp3_room", 32'(bus.disp_ready_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      disp(1, 4'(i), 0, 32'(i * 256), 32'(i + 1), 0, 0);
      bus.lsu_read_i = 1'b1;
      cycle();
    end
    drain();

    // Store data bypassed from a same-cycle broadcast, then push+pop at count 2
    disp(0, 0, 0, 32'h40, 0, 4'd3, 32'h0);
    bus.cdb_tag_i = 4'd3; bus.cdb_data_i = 32'h55;
    cycle(); idle();
    chk("tp4_rdy", 32'(bus.lsu_instr_ready_o), 32'd1);
    chk("tp4_st",  bus.lsu_st_data_o, 32'h55);
    disp(1, 4'd6, 0, 32'h80, 32'h8, 0, 0);
    cycle();
    disp(1, 4'd7, 0, 32'h90, 32'h8, 0, 0);
    bus.lsu_read_i = 1'b1;
    cycle(); idle();
    chk("tp4_cnt", 32'(count), 32'd2);
    drain();

    // Stalled head store blocks a ready load behind it
    disp(0, 0, 0, 32'h200, 0, 4'd5, 0);
    cycle();
    disp(1, 4'd8, 0, 32'h300, 0, 0, 0);
    cycle(); idle();
    bus.lsu_read_i = 1'b1;
    repeat (3) cycle();
    chk("tp5_block", 32'(bus.lsu_instr_ready_o), 32'd0);
    chk("tp5_cnt",   32'(count), 32'd2);
    bus.lsu_read_i = 1'b0;
    bus.cdb_tag_i = 4'd5; bus.cdb_data_i = 32'h77;
    cycle(); idle();
    chk("tp5_st", bus.lsu_st_data_o, 32'h77);
    bus.lsu_read_i = 1'b1;
    cycle();
    chk("tp5_next", 32'(bus.lsu_load_o), 32'd1);
    cycle(); idle();

    // Asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) begin
      disp(0, 0, 4'd9, 32'(i), 0, 0, 0);
      cycle();
    end
    idle();
    rst_n = 1'b0;
    #1;
    chk("tp6_empty", 32'(bus.lsu_empty_o), 32'd1);
    chk("tp6_cnt",   32'(count), 32'd0);
    chk("tp6_rdy",   32'(bus.lsu_instr_ready_o), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    disp(1, 4'd2, 0, 32'h1000, 32'h20, 0, 0);
    cycle(); idle();
    chk("tp6_after", bus.lsu_eff_addr_o, 32'h1020);
    drain();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 2) != 0) begin
        disp($urandom_range(0, 1), 4'($urandom_range(0, 7)),
             ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
             $urandom, $urandom,
             ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0,
             $urandom);
        if (bus.disp_load_i == 1'b0) bus.disp_ld_tag_i = '0;
      end
      if ($urandom_range(0, 1) != 0) begin
        bus.cdb_tag_i  = 4'($urandom_range(0, 7));
        bus.cdb_data_i = $urandom;
      end
      bus.lsu_read_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) pulse_reset();
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
